// File: rtl/audio_decimator.sv
// rtl/audio_decimator.sv - block-average decimator feeding a small FIFO and a start/done handshake
// Samples are summed in groups of DECIMATE, averaged by arithmetic shift, and bits [17:6] of the average are queued.
module audio_decimator #(
  parameter int DECIMATE   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ready,
  input  logic signed [17:0]            from_codec,
  input  logic                          done,
  output logic                          start,
  output logic signed [11:0]            sample_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int LOG2D = $clog2(DECIMATE);
  localparam int ACC_W = 18 + LOG2D;
  localparam int PH_W  = (LOG2D > 0) ? LOG2D : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIMATE - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, GUARD, WAIT_DONE} state_t;

  logic signed [ACC_W-1:0] acc_q, acc_d, sum;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic                    wr_pend_q, wr_pend_d;
  logic signed [11:0]      wr_data_q, wr_data_d;
  logic signed [11:0]      mem_q [FIFO_DEPTH];
  logic signed [11:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    overflow_q, overflow_d;
  state_t                  state_q, state_d;
  logic                    start_q, start_d;
  logic signed [11:0]      sample_q, sample_d;
  logic                    rd_en, wr_en, full;

  always_comb begin
    acc_d     = acc_q;
    phase_d   = phase_q;
    wr_pend_d = 1'b0;
    wr_data_d = wr_data_q;
    sum       = acc_q + ACC_W'(from_codec);
    if (ready) begin
      if (phase_q == PH_LAST) begin
        // Average and the [17:6] field selection fold into one arithmetic shift.
        acc_d     = '0;
        phase_d   = '0;
        wr_pend_d = 1'b1;
        wr_data_d = 12'(sum >>> (LOG2D + 6));
      end else begin
        acc_d   = sum;
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_comb begin
    full       = (count_q == CNT_FULL);
    rd_en      = (state_q == IDLE) && (count_q != '0);
    wr_en      = wr_pend_q && (!full || rd_en);
    overflow_d = overflow_q | (wr_pend_q && full && !rd_en);
    wptr_d     = wr_en ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = rd_en ? rptr_q + 1'b1 : rptr_q;
    mem_d      = mem_q;
    if (wr_en) mem_d[wptr_q] = wr_data_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    sample_d = sample_q;
    case (state_q)
      IDLE: begin
        if (rd_en) begin
          sample_d = mem_q[rptr_q];
          start_d  = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE:     state_d = GUARD;
      // Downstream is still lowering done here, so it is not looked at.
      GUARD:     state_d = WAIT_DONE;
      WAIT_DONE: if (done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      phase_q    <= '0;
      wr_pend_q  <= 1'b0;
      wr_data_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      start_q    <= 1'b0;
      sample_q   <= '0;
    end else begin
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      wr_pend_q  <= wr_pend_d;
      wr_data_q  <= wr_data_d;
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      start_q    <= start_d;
      sample_q   <= sample_d;
    end
  end

  assign start      = start_q;
  assign sample_out = sample_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_audio_decimator.sv
// tb/tb_audio_decimator.sv - directed vector bench for audio_decimator
// Two instances: DECIMATE=2 for averaging/handshake/reset cases, DECIMATE=1 for FIFO rate cases.
module tb_audio_decimator;

  logic               clock = 1'b0;
  logic               reset, ready, done;
  logic signed [17:0] from_codec;
  logic               start, overflow;
  logic signed [11:0] sample_out;
  logic [2:0]         fifo_count;

  logic               reset1, ready1, done1;
  logic signed [17:0] from_codec1;
  logic               start1, overflow1;
  logic signed [11:0] sample_out1;
  logic [2:0]         fifo_count1;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_start1 = 0;
  logic [11:0] got_q[$];

  audio_decimator #(.DECIMATE(2), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .ready(ready), .from_codec(from_codec), .done(done),
    .start(start), .sample_out(sample_out), .fifo_count(fifo_count), .overflow(overflow)
  );

  audio_decimator #(.DECIMATE(1), .FIFO_DEPTH(4)) dut1 (
    .clock(clock), .reset(reset1), .ready(ready1), .from_codec(from_codec1), .done(done1),
    .start(start1), .sample_out(sample_out1), .fifo_count(fifo_count1), .overflow(overflow1)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (start) got_q.push_back(sample_out);
    if (start1) n_start1++;
  end

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    logic [11:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [17:0] s);
    @(negedge clock);
    ready = 1'b1;
    from_codec = s;
    @(negedge clock);
    ready = 1'b0;
    from_codec = '0;
  endtask

  task automatic send_group(input logic [11:0] v);
    pulse({v, 6'd0});
    pulse({v, 6'd0});
  endtask

  task automatic wait_size(input int n, input int budget);
    for (int k = 0; k < budget && got_q.size() < n; k++) @(negedge clock);
  endtask

  function automatic logic [11:0] got_at(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return 12'hxxx;
  endfunction

  initial begin
    vec_t vecs[9];
    int base;
    int max1;
    vecs[0] = '{18'h00400, 18'h00C00, 12'h020};
    vecs[1] = '{18'h3FFC0, 18'h3FFBF, 12'hFFE};
    vecs[2] = '{18'h1FFFF, 18'h1FFFF, 12'h7FF};
    vecs[3] = '{18'h20000, 18'h20000, 12'h800};
    vecs[4] = '{18'h1FFFF, 18'h20000, 12'hFFF};
    vecs[5] = '{18'h00040, 18'h00000, 12'h000};
    vecs[6] = '{18'h00080, 18'h00001, 12'h001};
    vecs[7] = '{18'h12345, 18'h00000, 12'h246};
    vecs[8] = '{18'h00000, 18'h00000, 12'h000};

    reset = 1'b1; ready = 1'b0; from_codec = '0; done = 1'b1;
    reset1 = 1'b1; ready1 = 1'b0; from_codec1 = '0; done1 = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_sample", {20'd0, sample_out}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0; reset1 = 1'b0;
    repeat (2) @(negedge clock);

    // Averaging vectors, done held high.
    for (int i = 0; i < 9; i++) begin
      base = got_q.size();
      pulse(vecs[i].a);
      pulse(vecs[i].b);
      wait_size(base + 1, 20);
      repeat (3) @(negedge clock);
      check($sformatf("vec%0d_starts", i), got_q.size() - base, 1);
      check($sformatf("vec%0d_value", i), {20'd0, got_at(base)}, {20'd0, vecs[i].exp});
      check($sformatf("vec%0d_held", i), {20'd0, sample_out}, {20'd0, vecs[i].exp});
    end

    // Downstream stalled: one issued, four queued, sixth dropped.
    done = 1'b0;
    base = got_q.size();
    for (int g = 1; g <= 6; g++) send_group(12'(g));
    repeat (1000) @(negedge clock);
    check("stall_starts", got_q.size() - base, 1);
    check("stall_first", {20'd0, got_at(base)}, 32'd1);
    check("stall_held", {20'd0, sample_out}, 32'd1);
    check("stall_count", {29'd0, fifo_count}, 32'd4);
    check("stall_overflow", {31'd0, overflow}, 32'd1);
    done = 1'b1;
    wait_size(base + 5, 100);
    repeat (10) @(negedge clock);
    check("drain_starts", got_q.size() - base, 5);
    for (int g = 2; g <= 5; g++)
      check($sformatf("drain_order%0d", g), {20'd0, got_at(base + g - 1)}, g);
    check("drain_count", {29'd0, fifo_count}, 32'd0);
    check("drain_overflow_sticky", {31'd0, overflow}, 32'd1);

    // done drops in GUARD and returns 10 cycles later.
    base = got_q.size();
    fork
      begin
        send_group(12'd7);
        send_group(12'd8);
      end
      begin
        wait_size(base + 1, 40);
        done = 1'b0;
        repeat (10) @(negedge clock);
        check("guard_hold", got_q.size() - base, 1);
        done = 1'b1;
      end
    join
    wait_size(base + 2, 40);
    repeat (5) @(negedge clock);
    check("guard_starts", got_q.size() - base, 2);
    check("guard_first", {20'd0, got_at(base)}, 32'd7);
    check("guard_second", {20'd0, got_at(base + 1)}, 32'd8);

    // Reset while waiting on done with two entries queued and a partial group.
    done = 1'b0;
    for (int g = 9; g <= 11; g++) send_group(12'(g));
    repeat (10) @(negedge clock);
    check("pre_rst_count", {29'd0, fifo_count}, 32'd2);
    check("pre_rst_sample", {20'd0, sample_out}, 32'd9);
    pulse(18'h1F000);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("async_sample", {20'd0, sample_out}, 32'd0);
    check("async_count", {29'd0, fifo_count}, 32'd0);
    check("async_overflow", {31'd0, overflow}, 32'd0);
    check("async_start", {31'd0, start}, 32'd0);
    done = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    base = got_q.size();
    repeat (20) @(negedge clock);
    check("post_rst_quiet", got_q.size() - base, 0);
    pulse(18'h00400);
    repeat (10) @(negedge clock);
    check("post_rst_half", got_q.size() - base, 0);
    pulse(18'h00C00);
    wait_size(base + 1, 20);
    repeat (3) @(negedge clock);
    check("post_rst_starts", got_q.size() - base, 1);
    check("post_rst_value", {20'd0, got_at(base)}, 32'h020);

    // DECIMATE=1, ready every 3 cycles: producer outruns the 4-cycle handshake.
    max1 = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      ready1 = (k % 3 == 0);
      from_codec1 = 18'(k << 6);
      if (int'(fifo_count1) > max1) max1 = int'(fifo_count1);
    end
    ready1 = 1'b0;
    check("d1_fast_max", max1, 4);
    check("d1_fast_overflow", {31'd0, overflow1}, 32'd1);
    @(negedge clock);
    reset1 = 1'b1;
    @(negedge clock);
    reset1 = 1'b0;
    check("d1_rst_overflow", {31'd0, overflow1}, 32'd0);

    // Ready every 4 cycles matches the handshake rate exactly.
    max1 = 0;
    base = n_start1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      ready1 = (k % 4 == 0);
      from_codec1 = 18'(k << 6);
      if (int'(fifo_count1) > max1) max1 = int'(fifo_count1);
    end
    ready1 = 1'b0;
    repeat (12) @(negedge clock);
    check("d1_slow_max", max1, 1);
    check("d1_slow_overflow", {31'd0, overflow1}, 32'd0);
    check("d1_slow_starts", n_start1 - base, 75);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
